serial_command_rx: RTL and testbench
====================================

SERIAL_COMMAND_RX -- requirements
Module: serial_command_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of rx_pin synchroniser flops, minimum 2.
REQ-002 SHALL have parameter CMD_RECORD, default 8'h52 ('R'): command byte for record_start.
REQ-003 SHALL have parameter CMD_TRIGGER, default 8'h54 ('T'): command byte for record_trigger.
REQ-004 SHALL have parameter CMD_DUMP, default 8'h44 ('D'): command byte for dump_start.
REQ-005 comm_clock  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clocks_per_bit  in  12  comm_clock cycles per serial bit, legal range 4..4095.
REQ-008 rx_pin  in  1  asynchronous serial line, idle high, 8N1 frame (8E1 under REQ-030).
REQ-009 out_data  out  8  last good received byte.
REQ-010 available  out  1  out_data holds an unacknowledged byte.
REQ-011 acknowledge  in  1  consumer has taken out_data.
REQ-012 error  out  1  sticky framing, overrun or parity error.
REQ-013 record_start, record_trigger, dump_start  out  1 each  single-cycle command pulses.

Function
REQ-014 rx_pin SHALL pass through SYNC_STAGES flops; all decoding SHALL use the final stage ("rxs").
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START SHALL occur on the first edge with rxs==0 and armed==1; clocks_per_bit SHALL be latched on that edge and held for the frame.
REQ-017 In START, rxs SHALL be sampled floor(cpb/2) cycles after entry; if rxs==1 -> IDLE (false start, no error), else -> DATA.
REQ-018 In DATA, bits SHALL be sampled every cpb cycles, shifted in LSB first; after bit 7 -> STOP (PARITY under REQ-030).
REQ-019 In STOP, rxs SHALL be sampled cpb cycles after the last data/parity sample; FSM SHALL return to IDLE on that same edge, so back-to-back frames are received.
REQ-020 On a stop sample of 1 (and no parity error), out_data and available SHALL update on the stop-sample edge.
REQ-021 On a stop sample of 0, error SHALL be set, out_data and available SHALL be unchanged, no command pulse SHALL fire, and armed SHALL clear until rxs==1 is seen.
REQ-022 acknowledge SHALL clear available on the next edge; acknowledge while available==0 SHALL have no effect.
REQ-023 A good byte completing while available==1 and acknowledge==0 SHALL overwrite out_data, keep available==1 and set error (overrun).
REQ-024 A good byte completing on the same edge as acknowledge SHALL leave available==1 with the new byte and SHALL NOT set error.
REQ-025 error SHALL clear only on an edge with acknowledge==1 and no new error event; a simultaneous new error SHALL win.
REQ-026 On a good byte equal to CMD_RECORD, CMD_TRIGGER or CMD_DUMP, the matching pulse SHALL be high for exactly the one cycle following the stop-sample edge; other bytes SHALL produce no pulse.
REQ-027 Command pulses SHALL fire regardless of available or acknowledge state.

Reset
REQ-028 While reset==0: FSM=IDLE, synchroniser flops=1, shift register=0, out_data=8'h00, available=0, error=0, all pulses=0, armed=0.
REQ-029 After release, armed SHALL set only after rxs==1 is sampled, so a frame in progress at release is never decoded; reset mid-frame SHALL discard the partial byte.

Configuration
REQ-030 With SERIAL_COMMAND_RX_PARITY_EN defined, a PARITY state SHALL sample an even-parity bit cpb cycles after bit 7; a mismatch SHALL set error and suppress out_data, available and pulses for that frame, with the stop bit still sampled. Without the macro, the PARITY state and its logic SHALL be absent and frames SHALL be 8N1.

Verification (cpb=32, SYNC_STAGES=2, reset released, line idle)
REQ-031 Send 0x52 -> out_data=0x52, available=1, record_start high exactly 1 cycle, other pulses 0, error=0.
REQ-032 Send 0x41 then 0x44 back-to-back with no acknowledge -> out_data=0x44, error=1 (overrun), dump_start pulse once; acknowledge -> available=0, error=0.
REQ-033 Low glitch on rx_pin of 8 cycles -> FSM returns to IDLE, no available, no error.
REQ-034 Frame 0x54 with stop bit driven 0 -> error=1, available=0, no record_trigger pulse; next 0x54 after idle -> record_trigger pulse.
REQ-035 Assert reset after data bit 3 of a 0x52 frame, release before the frame ends -> no byte, no pulse; following 0x44 decodes correctly.
REQ-036 With SERIAL_COMMAND_RX_PARITY_EN: 0x52 with correct parity 1 -> record_start pulse; with parity 0 -> error=1, no pulse.

Source files
------------

// File: rtl/serial_command_rx_if.sv
// serial_command_rx_if: consumer handshake and command pulses of serial_command_rx
interface serial_command_rx_if;
  logic [7:0] out_data;
  logic       available;
  logic       acknowledge;
  logic       error;
  logic       record_start;
  logic       record_trigger;
  logic       dump_start;
  modport master (
    output out_data, available, error, record_start, record_trigger, dump_start,
    input  acknowledge
  );
  modport slave (
    input  out_data, available, error, record_start, record_trigger, dump_start,
    output acknowledge
  );
endinterface

// File: rtl/serial_command_rx.sv
// serial_command_rx: UART byte receiver with command-pulse decode; define SERIAL_COMMAND_RX_PARITY_EN for 8E1 frames
module serial_command_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_RECORD  = 8'h52,
  parameter logic [7:0] CMD_TRIGGER = 8'h54,
  parameter logic [7:0] CMD_DUMP    = 8'h44
) (
  input  logic                comm_clock,
  input  logic                reset,
  input  logic [11:0]         clocks_per_bit,
  input  logic                rx_pin,
  serial_command_rx_if.master bus
);
`ifdef SERIAL_COMMAND_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bad;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic par_bad = 1'b0;
`endif
  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] primed;
  logic                   rxs, armed, tick, stop_tick, good, bad, err_evt;
  logic [11:0]            cpb, cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  assign rxs = sync[SYNC_STAGES-1];
  // Synchroniser chain; primed marks when rxs reflects the real pin rather than reset values
  always_ff @(posedge comm_clock or negedge reset)
    if (!reset) begin
      sync   <= '1;
      primed <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], rx_pin};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  // State register
  always_ff @(posedge comm_clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // Next-state: start detection, half-bit start check, data bits, optional parity, stop
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!rxs && armed) ? START : IDLE;
      START:   if (tick) state_n = rxs ? IDLE : DATA;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
      DATA:    if (tick && bit_idx == 3'd7) state_n = PARITY;
      PARITY:  if (tick) state_n = STOP;
`else
      DATA:    if (tick && bit_idx == 3'd7) state_n = STOP;
`endif
      STOP:    if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Sample strobes and frame outcome; the start bit is checked at half a bit period
  always_comb begin
    tick      = cnt == (state == START ? {1'b0, cpb[11:1]} : cpb);
    stop_tick = state == STOP && tick;
    good      = stop_tick && rxs && !par_bad;
    bad       = stop_tick && (!rxs || par_bad);
    err_evt   = bad || (good && bus.available && !bus.acknowledge);
  end
  // Bit timing, shift register and line arming; cpb is frozen once a frame starts
  always_ff @(posedge comm_clock or negedge reset)
    if (!reset) begin
      cpb     <= '0;
      cnt     <= 12'd1;
      bit_idx <= '0;
      shift   <= '0;
      armed   <= 1'b0;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      armed <= (primed[SYNC_STAGES-1] && rxs) || (armed && !(stop_tick && !rxs));
      cnt   <= (state == IDLE || tick) ? 12'd1 : cnt + 12'd1;
      if (state == IDLE) begin
        cpb     <= clocks_per_bit;
        bit_idx <= '0;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
        par_bad <= 1'b0;
`endif
      end
      if (state == DATA && tick) begin
        shift   <= {rxs, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef SERIAL_COMMAND_RX_PARITY_EN
      if (state == PARITY && tick) par_bad <= rxs != ^shift;
`endif
    end
  // Consumer handshake, sticky error and one-cycle command pulses
  always_ff @(posedge comm_clock or negedge reset)
    if (!reset) begin
      bus.out_data       <= '0;
      bus.available      <= 1'b0;
      bus.error          <= 1'b0;
      bus.record_start   <= 1'b0;
      bus.record_trigger <= 1'b0;
      bus.dump_start     <= 1'b0;
    end else begin
      bus.available      <= good || (bus.available && !bus.acknowledge);
      bus.error          <= err_evt || (bus.error && !bus.acknowledge);
      bus.out_data       <= good ? shift : bus.out_data;
      bus.record_start   <= good && shift == CMD_RECORD;
      bus.record_trigger <= good && shift == CMD_TRIGGER;
      bus.dump_start     <= good && shift == CMD_DUMP;
    end
endmodule

// File: tb/tb_serial_command_rx.sv
// tb_serial_command_rx: directed bench for serial_command_rx at 32 clocks per bit
module tb_serial_command_rx;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_CYC = 19 + 32 * (NBITS - 1);
  logic        comm_clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_pin = 1'b1;
  logic [11:0] clocks_per_bit = 12'd32;
  int checks = 0, errors = 0;
  int rec_cnt = 0, trig_cnt = 0, dump_cnt = 0;
  serial_command_rx_if bus();
  serial_command_rx dut (
    .comm_clock(comm_clock),
    .reset(reset),
    .clocks_per_bit(clocks_per_bit),
    .rx_pin(rx_pin),
    .bus(bus)
  );
  always #5 comm_clock = ~comm_clock;
  // Count pulse-high cycles, sampled on the falling edge
  always @(negedge comm_clock) begin
    if (bus.record_start) rec_cnt++;
    if (bus.record_trigger) trig_cnt++;
    if (bus.dump_start) dump_cnt++;
  end
  // Drive one frame a clock at a time; optional acknowledge cycle and reset window by cycle index
  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v,
                      input int ack_cyc, input int rst_lo, input int rst_hi);
    logic [10:0] f;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
    f = {stop_v, par_v, b, 1'b0};
`else
    f = {1'b0, stop_v, b, 1'b0};
`endif
    for (int c = 0; c < NBITS * 32; c++) begin
      rx_pin = f[c / 32];
      bus.acknowledge = (c == ack_cyc);
      if (c == rst_lo) reset = 1'b0;
      if (c == rst_hi) reset = 1'b1;
      @(negedge comm_clock);
    end
    rx_pin = 1'b1;
    bus.acknowledge = 1'b0;
  endtask
  task automatic send_good(input logic [7:0] b);
    send(b, 1'b1, ^b, -1, -1, -1);
  endtask
  task automatic do_ack;
    bus.acknowledge = 1'b1;
    @(negedge comm_clock);
    bus.acknowledge = 1'b0;
    @(negedge comm_clock);
  endtask
  task automatic test_reset;
    bus.acknowledge = 1'b0;
    repeat (3) @(negedge comm_clock);
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL reset available: got %b expected 0", bus.available); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset error: got %b expected 0", bus.error); end
    checks++; if (bus.record_start !== 1'b0) begin errors++; $display("FAIL reset record_start: got %b expected 0", bus.record_start); end
    checks++; if (bus.record_trigger !== 1'b0) begin errors++; $display("FAIL reset record_trigger: got %b expected 0", bus.record_trigger); end
    checks++; if (bus.dump_start !== 1'b0) begin errors++; $display("FAIL reset dump_start: got %b expected 0", bus.dump_start); end
    reset = 1'b1;
    repeat (10) @(negedge comm_clock);
  endtask
  task automatic test_record;
    int r0, t0, d0;
    r0 = rec_cnt; t0 = trig_cnt; d0 = dump_cnt;
    send_good(8'h52);
    checks++; if (bus.out_data !== 8'h52) begin errors++; $display("FAIL record out_data: got %h expected 52", bus.out_data); end
    checks++; if (bus.available !== 1'b1) begin errors++; $display("FAIL record available: got %b expected 1", bus.available); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL record error: got %b expected 0", bus.error); end
    checks++; if (rec_cnt - r0 !== 1) begin errors++; $display("FAIL record record_start cycles: got %0d expected 1", rec_cnt - r0); end
    checks++; if (trig_cnt - t0 !== 0 || dump_cnt - d0 !== 0) begin errors++; $display("FAIL record other pulses: got %0d/%0d expected 0/0", trig_cnt - t0, dump_cnt - d0); end
    do_ack;
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL record ack available: got %b expected 0", bus.available); end
  endtask
  task automatic test_back_to_back;
    int r0, d0;
    r0 = rec_cnt; d0 = dump_cnt;
    send_good(8'h41);
    send_good(8'h44);
    checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL b2b out_data: got %h expected 44", bus.out_data); end
    checks++; if (bus.available !== 1'b1) begin errors++; $display("FAIL b2b available: got %b expected 1", bus.available); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL b2b overrun error: got %b expected 1", bus.error); end
    checks++; if (dump_cnt - d0 !== 1) begin errors++; $display("FAIL b2b dump_start cycles: got %0d expected 1", dump_cnt - d0); end
    checks++; if (rec_cnt - r0 !== 0) begin errors++; $display("FAIL b2b record_start cycles: got %0d expected 0", rec_cnt - r0); end
    do_ack;
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL b2b ack available: got %b expected 0", bus.available); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL b2b ack error: got %b expected 0", bus.error); end
  endtask
  task automatic test_glitch;
    int p0;
    p0 = rec_cnt + trig_cnt + dump_cnt;
    rx_pin = 1'b0;
    repeat (8) @(negedge comm_clock);
    rx_pin = 1'b1;
    repeat (400) @(negedge comm_clock);
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL glitch available: got %b expected 0", bus.available); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL glitch error: got %b expected 0", bus.error); end
    checks++; if (rec_cnt + trig_cnt + dump_cnt - p0 !== 0) begin errors++; $display("FAIL glitch pulses: got %0d expected 0", rec_cnt + trig_cnt + dump_cnt - p0); end
  endtask
  task automatic test_stop_error;
    int t0;
    t0 = trig_cnt;
    send(8'h54, 1'b0, ^8'h54, -1, -1, -1);
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL stoperr error: got %b expected 1", bus.error); end
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL stoperr available: got %b expected 0", bus.available); end
    checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL stoperr out_data: got %h expected 44", bus.out_data); end
    checks++; if (trig_cnt - t0 !== 0) begin errors++; $display("FAIL stoperr record_trigger cycles: got %0d expected 0", trig_cnt - t0); end
    repeat (40) @(negedge comm_clock);
    send_good(8'h54);
    checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL stoperr retry record_trigger cycles: got %0d expected 1", trig_cnt - t0); end
    checks++; if (bus.out_data !== 8'h54) begin errors++; $display("FAIL stoperr retry out_data: got %h expected 54", bus.out_data); end
    do_ack;
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL stoperr ack error: got %b expected 0", bus.error); end
  endtask
  task automatic test_ack_collision;
    send_good(8'h41);
    send(8'h44, 1'b1, ^8'h44, STOP_CYC - 1, -1, -1);
    checks++; if (bus.available !== 1'b1) begin errors++; $display("FAIL collide available: got %b expected 1", bus.available); end
    checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL collide out_data: got %h expected 44", bus.out_data); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL collide error: got %b expected 0", bus.error); end
    do_ack;
    do_ack;
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL idle ack available: got %b expected 0", bus.available); end
  endtask
  task automatic test_reset_midframe;
    int p0, d0;
    p0 = rec_cnt + trig_cnt + dump_cnt;
    send(8'h52, 1'b1, ^8'h52, -1, 160, 256);
    repeat (64) @(negedge comm_clock);
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL midreset available: got %b expected 0", bus.available); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL midreset out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL midreset error: got %b expected 0", bus.error); end
    checks++; if (rec_cnt + trig_cnt + dump_cnt - p0 !== 0) begin errors++; $display("FAIL midreset pulses: got %0d expected 0", rec_cnt + trig_cnt + dump_cnt - p0); end
    d0 = dump_cnt;
    send_good(8'h44);
    checks++; if (bus.out_data !== 8'h44) begin errors++; $display("FAIL midreset next out_data: got %h expected 44", bus.out_data); end
    checks++; if (dump_cnt - d0 !== 1) begin errors++; $display("FAIL midreset next dump_start cycles: got %0d expected 1", dump_cnt - d0); end
    do_ack;
  endtask
`ifdef SERIAL_COMMAND_RX_PARITY_EN
  task automatic test_parity;
    int r0;
    r0 = rec_cnt;
    send(8'h52, 1'b1, 1'b1, -1, -1, -1);
    checks++; if (rec_cnt - r0 !== 1) begin errors++; $display("FAIL parity good record_start cycles: got %0d expected 1", rec_cnt - r0); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL parity good error: got %b expected 0", bus.error); end
    do_ack;
    r0 = rec_cnt;
    send(8'h52, 1'b1, 1'b0, -1, -1, -1);
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL parity bad error: got %b expected 1", bus.error); end
    checks++; if (bus.available !== 1'b0) begin errors++; $display("FAIL parity bad available: got %b expected 0", bus.available); end
    checks++; if (rec_cnt - r0 !== 0) begin errors++; $display("FAIL parity bad record_start cycles: got %0d expected 0", rec_cnt - r0); end
    do_ack;
  endtask
`endif
  initial begin
    bus.acknowledge = 1'b0;
    test_reset;
    test_record;
    test_back_to_back;
    test_glitch;
    test_stop_error;
    test_ack_collision;
    test_reset_midframe;
`ifdef SERIAL_COMMAND_RX_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
